// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO family
package fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   // Number of words addressed by an ASIZE-bit pointer.
   function automatic int fifo_depth(input int asize);
      return 1 << asize;
   endfunction

   // Almost-full must sit strictly above almost-empty, and both must be
   // reachable by the occupancy counter.
   function automatic bit fifo_levels_ok(input int depth, input int af_level,
                                         input int ae_level);
      return (af_level >= 1) && (af_level <= depth) &&
             (ae_level >= 0) && (ae_level <= depth - 1) &&
             (ae_level < af_level);
   endfunction

endpackage

// File: rtl/sync_fifomem.sv
// rtl/sync_fifomem.sv - FIFO storage array with selectable read-port timing
module sync_fifomem
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4,
   parameter int FWFT  = FWFT_OFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic             re_i,
   input  logic [ASIZE-1:0] raddr_i,
   output logic [DSIZE-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(ASIZE);

   // Storage is deliberately not reset; the pointers decide what is valid.
   logic [DSIZE-1:0] mem_q [DEPTH];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   generate
      if (FWFT == FWFT_OFF) begin : g_reg_read
         logic [DSIZE-1:0] rdata_q;

         // Registered read: output updates only on an accepted pop and holds otherwise.
         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_q <= '0;
            end else if (re_i) begin
               rdata_q <= mem_q[raddr_i];
            end
         end

         assign rdata_o = rdata_q;
      end else begin : g_fwft_read
         // The head word is always on the output; pops only move raddr.
         logic unused_ok;
         assign unused_ok = &{1'b0, rst, re_i};
         assign rdata_o   = mem_q[raddr_i];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with count, thresholds, flush and sticky errors
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DSIZE    = 8,
   parameter int ASIZE    = 4,
   parameter int FWFT     = FWFT_OFF,
   parameter int AF_LEVEL = fifo_depth(ASIZE) - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   input  logic             flush,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = fifo_depth(ASIZE);
   localparam logic [ASIZE:0] CNT_FULL = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
   localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);

   generate
      if (!fifo_levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
         $fatal(1, "sync_fifo_param: illegal AF_LEVEL/AE_LEVEL for this DEPTH");
      end
   endgenerate

   logic [ASIZE-1:0] waddr_q, waddr_d;
   logic [ASIZE-1:0] raddr_q, raddr_d;
   logic [ASIZE:0]   count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             we, re;

   // Every status output is a decode of registered state only.
   assign wfull         = (count_q == CNT_FULL);
   assign rempty        = (count_q == '0);
   assign walmost_full  = (count_q >= AF_CNT);
   assign ralmost_empty = (count_q <= AE_CNT);
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

   // Accept decisions, pointer/count next state and error accumulation.
   always_comb begin
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (winc & wfull);
      underflow_d = underflow_q | (rinc & rempty);
      we          = winc & ~wfull;
      re          = rinc & ~rempty;

      // Flush (and reset) cancel any request made in the same cycle.
      if (rst || flush) begin
         we          = 1'b0;
         re          = 1'b0;
         overflow_d  = overflow_q;
         underflow_d = underflow_q;
      end

      if (we) begin
         waddr_d = waddr_q + ASIZE'(1);
      end
      if (re) begin
         raddr_d = raddr_q + ASIZE'(1);
      end

      case ({we, re})
         2'b10:   count_d = count_q + (ASIZE+1)'(1);
         2'b01:   count_d = count_q - (ASIZE+1)'(1);
         default: count_d = count_q;
      endcase

      if (flush) begin
         waddr_d = '0;
         raddr_d = '0;
         count_d = '0;
      end
   end

   // Control registers; reset clears everything, flush is folded into _d.
   always_ff @(posedge clk) begin
      if (rst) begin
         waddr_q     <= '0;
         raddr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sync_fifomem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE),
      .FWFT  (FWFT)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .waddr_i (waddr_q),
      .wdata_i (wdata),
      .re_i    (re),
      .raddr_i (raddr_q),
      .rdata_o (rdata)
   );

   // Occupancy can never leave 0..DEPTH.
   a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_FULL)
      else $error("sync_fifo_param: count out of range");

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param in both read modes
module tb_sync_fifo_param;

   logic       clk;
   logic       rst;

   logic       w0, r0, f0;
   logic [7:0] wd0, rd0;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic [4:0] cnt0;

   logic       w1, r1, f1;
   logic [7:0] wd1, rd1;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic [4:0] cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       pend0 = 1'b0;

   sync_fifo_param #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut0 (
      .clk(clk), .rst(rst), .winc(w0), .wdata(wd0), .rinc(r0), .flush(f0),
      .rdata(rd0), .wfull(full0), .rempty(empty0), .walmost_full(af0),
      .ralmost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

   sync_fifo_param #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut1 (
      .clk(clk), .rst(rst), .winc(w1), .wdata(wd1), .rinc(r1), .flush(f1),
      .rdata(rd1), .wfull(full1), .rempty(empty1), .walmost_full(af1),
      .ralmost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Registered-read monitor: an accepted pop shows its word one cycle later.
   always @(negedge clk) begin
      if (pend0) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL rdata0_unexpected: got %0h expected none", rd0);
         end else begin
            logic [7:0] e;
            e = q0.pop_front();
            if (rd0 !== e) begin
               n_fail++;
               $display("FAIL rdata0: got %0h expected %0h", rd0, e);
            end
         end
      end
      pend0 = r0 && !empty0 && !rst && !f0;
   end

   // FWFT monitor: the head word must be on rdata when it is popped.
   always @(negedge clk) begin
      if (r1 && !empty1 && !rst && !f1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL rdata1_unexpected: got %0h expected none", rd1);
         end else begin
            logic [7:0] e;
            e = q1.pop_front();
            if (rd1 !== e) begin
               n_fail++;
               $display("FAIL rdata1: got %0h expected %0h", rd1, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      w0 = 0; r0 = 0; f0 = 0; wd0 = '0;
      w1 = 0; r1 = 0; f1 = 0; wd1 = '0;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();

      check("rst_rempty",    empty0, 1);
      check("rst_wfull",     full0,  0);
      check("rst_count",     cnt0,   0);
      check("rst_ae",        ae0,    1);
      check("rst_af",        af0,    0);
      check("rst_overflow",  ovf0,   0);
      check("rst_underflow", udf0,   0);
      check("rst_rdata",     rd0,    0);

      // Fill 0x00..0x0F and watch thresholds move.
      for (int i = 0; i < 16; i++) begin
         w0 = 1; wd0 = 8'(i);
         q0.push_back(8'(i));
         step();
         check("fill_count", cnt0,  i + 1);
         check("fill_ae",    ae0,   (i + 1 <= 2)  ? 1 : 0);
         check("fill_af",    af0,   (i + 1 >= 14) ? 1 : 0);
         check("fill_wfull", full0, (i + 1 == 16) ? 1 : 0);
      end
      w0 = 0;

      // Full with both requests: pop 0x00, reject 0xEE.
      w0 = 1; r0 = 1; wd0 = 8'hEE;
      step();
      w0 = 0; r0 = 0;
      check("fullrw_count",    cnt0,  15);
      check("fullrw_overflow", ovf0,  1);
      check("fullrw_wfull",    full0, 0);

      r0 = 1;
      repeat (15) step();
      r0 = 0;
      step();
      check("drain_rempty", empty0, 1);
      check("drain_count",  cnt0,   0);
      check("drain_rdata",  rd0,    8'h0F);

      // Empty with both requests: write 0x3C, reject the read.
      w0 = 1; r0 = 1; wd0 = 8'h3C;
      q0.push_back(8'h3C);
      step();
      w0 = 0; r0 = 0;
      check("emptyrw_count",     cnt0, 1);
      check("emptyrw_underflow", udf0, 1);
      r0 = 1;
      step();
      r0 = 0;
      step();
      check("emptyrw_rempty", empty0, 1);

      // Preload 8, then stream 40 cycles so both pointers wrap.
      for (int i = 0; i < 8; i++) begin
         w0 = 1; wd0 = 8'h40 + 8'(i);
         q0.push_back(8'h40 + 8'(i));
         step();
      end
      for (int i = 0; i < 40; i++) begin
         w0 = 1; r0 = 1; wd0 = 8'h48 + 8'(i);
         q0.push_back(8'h48 + 8'(i));
         step();
         check("stream_count", cnt0, 8);
      end
      w0 = 0; r0 = 0;
      step();
      check("stream_last_rdata", rd0, 8'h67);

      // Reach count 10 with overflow already set, then flush with a write.
      w0 = 1; wd0 = 8'h70; step();
      wd0 = 8'h71; step();
      w0 = 0;
      check("preflush_count", cnt0, 10);
      f0 = 1; w0 = 1; wd0 = 8'hFF;
      step();
      f0 = 0; w0 = 0;
      q0.delete();
      check("flush_count",     cnt0,   0);
      check("flush_rempty",    empty0, 1);
      check("flush_ae",        ae0,    1);
      check("flush_af",        af0,    0);
      check("flush_overflow",  ovf0,   1);
      check("flush_underflow", udf0,   1);
      check("flush_rdata",     rd0,    8'h67);

      // Normal operation after flush.
      w0 = 1; wd0 = 8'h5A;
      q0.push_back(8'h5A);
      step();
      w0 = 0; r0 = 1;
      step();
      r0 = 0;
      step();
      check("postflush_rempty", empty0, 1);

      rst = 1;
      step();
      rst = 0;
      step();
      check("rerst_overflow",  ovf0, 0);
      check("rerst_underflow", udf0, 0);
      check("rerst_rdata",     rd0,  0);
      check("rerst_count",     cnt0, 0);

      // FWFT: a single word appears without a read request.
      w1 = 1; wd1 = 8'hA5;
      q1.push_back(8'hA5);
      step();
      w1 = 0;
      check("fwft_rempty", empty1, 0);
      check("fwft_rdata",  rd1,    8'hA5);
      check("fwft_count",  cnt1,   1);
      r1 = 1;
      step();
      r1 = 0;
      check("fwft_pop_rempty", empty1, 1);

      for (int i = 0; i < 3; i++) begin
         w1 = 1; wd1 = 8'h11 * 8'(i + 1);
         q1.push_back(8'h11 * 8'(i + 1));
         step();
      end
      w1 = 0;
      check("fwft_head", rd1, 8'h11);
      r1 = 1;
      repeat (3) step();
      r1 = 0;
      step();
      check("fwft_end_rempty", empty1, 1);
      check("fwft_underflow",  udf1,   0);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
